// File: rtl/fp_complex_divider.sv
// Iterative signed fixed-point complex divider: c = a * conj(b) / |b|^2.
// Full-precision numerators/denominator, then one restoring-division step
// per cycle for the real and imaginary parts together (sharing den).
// Quotient magnitudes truncate toward zero and saturate to +/-(2^(n-1)-1).
module fp_complex_divider #(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] cr,
  output logic [n-1:0] cc,
  output logic         dbz
);

  localparam int W2 = 2 * n;          // full product width
  localparam int W1 = 2 * n + 1;      // numerator / denominator width
  localparam int K  = 2 * n + d;      // quotient bits = division steps
  localparam int CW = $clog2(K + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [n-1:0] MAXP = {1'b0, {(n-1){1'b1}}};

  logic [1:0]            state;
  logic signed [n-1:0]   ar_q, ac_q, br_q, bc_q;
  logic [CW-1:0]         cnt;
  logic [W1-1:0]         den_q;
  logic [1:0]            neg_q;
  // Dividend shift register; quotient bits shift in at the LSB, so after K
  // steps it holds the quotient.
  logic [1:0][K-1:0]     div_q;
  logic [1:0][W1-1:0]    rem_q;

  logic signed [W2-1:0]  p_rr, p_cc, p_cr, p_rc, p_bb, p_dd;
  logic [1:0][W1-1:0]    num, mag, rem_nx;
  logic [1:0][W1:0]      rem_sh;
  logic [1:0]            ge;
  logic [1:0][K-1:0]     quo;
  logic [1:0][n-1:0]     mag_sat, res;
  logic [W1-1:0]         den_c;

  assign recv_rdy = (state == S_IDLE);

  assign p_rr  = W2'(ar_q) * W2'(br_q);
  assign p_cc  = W2'(ac_q) * W2'(bc_q);
  assign p_cr  = W2'(ac_q) * W2'(br_q);
  assign p_rc  = W2'(ar_q) * W2'(bc_q);
  assign p_bb  = W2'(br_q) * W2'(br_q);
  assign p_dd  = W2'(bc_q) * W2'(bc_q);
  assign den_c = W1'(p_bb) + W1'(p_dd);

  // Numerators, magnitudes, one restoring step and the saturated result
  always_comb begin
    num     = '0;
    mag     = '0;
    rem_sh  = '0;
    ge      = '0;
    rem_nx  = '0;
    quo     = '0;
    mag_sat = '0;
    res     = '0;
    num[0]  = W1'(p_rr) + W1'(p_cc);
    num[1]  = W1'(p_cr) - W1'(p_rc);
    for (int i = 0; i < 2; i++) begin
      mag[i]     = num[i][W1-1] ? -num[i] : num[i];
      rem_sh[i]  = {rem_q[i], div_q[i][K-1]};
      ge[i]      = rem_sh[i] >= {1'b0, den_q};
      rem_nx[i]  = ge[i] ? W1'(rem_sh[i] - {1'b0, den_q}) : rem_sh[i][W1-1:0];
      quo[i]     = {div_q[i][K-2:0], ge[i]};
      mag_sat[i] = (quo[i] > K'(MAXP)) ? MAXP : quo[i][n-1:0];
      res[i]     = neg_q[i] ? -mag_sat[i] : mag_sat[i];
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      send_val <= 1'b0;
      cr       <= '0;
      cc       <= '0;
      dbz      <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (recv_val) begin
            ar_q  <= ar;
            ac_q  <= ac;
            br_q  <= br;
            bc_q  <= bc;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          den_q <= den_c;
          cnt   <= '0;
          for (int i = 0; i < 2; i++) begin
            neg_q[i] <= num[i][W1-1];
            div_q[i] <= K'({mag[i], {d{1'b0}}});
            rem_q[i] <= '0;
          end
          if (den_c == '0) begin
            cr    <= '0;
            cc    <= '0;
            dbz   <= 1'b1;
            state <= S_DONE;
          end else begin
            dbz   <= 1'b0;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          for (int i = 0; i < 2; i++) begin
            rem_q[i] <= rem_nx[i];
            div_q[i] <= quo[i];
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(K - 1)) begin
            cr    <= res[0];
            cc    <= res[1];
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // send_val is raised one cycle after entering DONE so it is a
          // pure register; the handshake returns to IDLE.
          if (send_val && send_rdy) begin
            send_val <= 1'b0;
            state    <= S_IDLE;
          end else begin
            send_val <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_complex_divider.sv
// Bench for fp_complex_divider: directed cases plus random operands checked
// against a wide-integer arithmetic model of c = a*conj(b)/|b|^2.
module tb_fp_complex_divider;
  localparam int N = 32;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset, recv_val, recv_rdy, send_val, send_rdy, dbz;
  logic [N-1:0] ar, ac, br, bc, cr, cc;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_complex_divider #(.n(N), .d(D)) dut (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .ar(ar), .ac(ac), .br(br), .bc(bc), .send_val(send_val),
    .send_rdy(send_rdy), .cr(cr), .cc(cc), .dbz(dbz)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] qdiv(input logic signed [127:0] num,
                                        input logic signed [127:0] den);
    logic signed [127:0] m, q;
    m = (num < 0) ? -num : num;
    q = (m <<< D) / den;
    if (q > 128'sd2147483647) q = 128'sd2147483647;
    if (num < 0) q = -q;
    return q[N-1:0];
  endfunction

  task automatic model(input logic [N-1:0] a_r, a_i, b_r, b_i,
                       output logic [N-1:0] qr, qi, output logic z);
    logic signed [127:0] xr, xi, yr, yi, nr, ni, dn;
    xr = longint'($signed(a_r));
    xi = longint'($signed(a_i));
    yr = longint'($signed(b_r));
    yi = longint'($signed(b_i));
    nr = xr * yr + xi * yi;
    ni = xi * yr - xr * yi;
    dn = yr * yr + yi * yi;
    z  = (dn == 0);
    qr = z ? '0 : qdiv(nr, dn);
    qi = z ? '0 : qdiv(ni, dn);
  endtask

  // One full transaction; hold = cycles of backpressure in DONE.
  task automatic txn(input logic [N-1:0] a_r, a_i, b_r, b_i, input int hold,
                     input logic early_rdy, output logic [N-1:0] got_r, got_i);
    logic [N-1:0] er, ei;
    logic ez, busy_ok, stable;
    int lat;
    model(a_r, a_i, b_r, b_i, er, ei, ez);
    @(negedge clk);
    chk("rdy_idle", recv_rdy, 1);
    ar = a_r; ac = a_i; br = b_r; bc = b_i;
    recv_val = 1'b1;
    send_rdy = early_rdy;
    @(negedge clk);
    recv_val = 1'b0;
    ar = $urandom; ac = $urandom; br = $urandom; bc = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (!send_val && lat < 300) begin
      if (recv_rdy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("busy_rdy_low", busy_ok, 1);
    chk("latency", lat, ez ? 2 : 82);
    chk("cr", cr, er);
    chk("cc", cc, ei);
    chk("dbz", dbz, ez);
    got_r = cr;
    got_i = cc;
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (cr !== got_r || cc !== got_i || !send_val || recv_rdy) stable = 1'b0;
      end
      chk("bp_stable", stable, 1);
    end
    send_rdy = 1'b1;
    @(negedge clk);
    chk("post_send_val", send_val, 0);
    chk("post_recv_rdy", recv_rdy, 1);
    send_rdy = 1'b0;
  endtask

  initial begin
    logic [N-1:0] gr, gi, rr, ri, sr, si;
    reset = 1'b0; recv_val = 1'b0; send_rdy = 1'b0;
    ar = '0; ac = '0; br = '0; bc = '0;
    repeat (3) @(negedge clk);
    chk("rst_recv_rdy", recv_rdy, 1);
    chk("rst_send_val", send_val, 0);
    chk("rst_cr", cr, 0);
    chk("rst_cc", cc, 0);
    chk("rst_dbz", dbz, 0);
    reset = 1'b1;

    txn(32'h00010000, 0, 32'h00010000, 0, 0, 1'b0, gr, gi);
    chk("ident_cr", gr, 32'h00010000);
    txn(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 0, 1'b1, gr, gi);
    chk("cplx_cr", gr, 32'h000070A3);
    chk("cplx_cc", gi, 32'h0000147A);
    txn(32'hFFFF0000, 0, 32'h00030000, 0, 0, 1'b0, gr, gi);
    chk("neg_cr", gr, 32'hFFFFAAAB);
    txn(32'h12345678, 32'h0000ABCD, 0, 0, 0, 1'b0, gr, gi);
    chk("dbz_cr", gr, 0);
    txn(32'h7FFF0000, 0, 32'h00000001, 0, 0, 1'b0, gr, gi);
    chk("satp_cr", gr, 32'h7FFFFFFF);
    txn(32'h80000000, 0, 32'h00000001, 0, 0, 1'b0, gr, gi);
    chk("satn_cr", gr, 32'h80000001);
    txn(32'hFFFD8000, 32'h00051234, 32'h00020000, 32'hFFFF4000, 20, 1'b0, gr, gi);

    // Reset in the middle of DIV, then a fresh transaction
    @(negedge clk);
    ar = 32'h00010000; ac = 32'h00020000; br = 32'h00030000; bc = 32'h00040000;
    recv_val = 1'b1;
    @(negedge clk);
    recv_val = 1'b0;
    repeat (41) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst_send_val", send_val, 0);
    chk("mid_rst_recv_rdy", recv_rdy, 1);
    chk("mid_rst_cr", cr, 0);
    chk("mid_rst_cc", cc, 0);
    txn(32'hFFFE0000, 32'h00008000, 32'h00008000, 32'hFFFF0000, 0, 1'b0, gr, gi);

    // Random operands with random magnitudes
    for (int k = 0; k < 16; k++) begin
      rr = $urandom; ri = $urandom; sr = $urandom; si = $urandom;
      rr = $signed(rr) >>> $urandom_range(0, 20);
      ri = $signed(ri) >>> $urandom_range(0, 20);
      sr = $signed(sr) >>> $urandom_range(4, 28);
      si = $signed(si) >>> $urandom_range(4, 28);
      if (k == 5) begin sr = '0; si = '0; end
      txn(rr, ri, sr, si, (k % 4 == 0) ? 3 : 0, k[0], gr, gi);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fp_complex_divider.md
# fp_complex_divider

Iterative signed fixed-point complex divider computing c = a / b on Qn-d.d operands. It is the inverse companion of the team's fixed-point complex multiplier: it undoes a complex scaling, e.g. equalization after channel estimation. It uses the same val/rdy handshake and the same operand/result port layout as the multiplier, so the two drop into the pipeline interchangeably. One transaction is in flight at a time.

## Interface
- n, 32: total bit width of every operand and result (two's complement)
- d, 16: fractional bits
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- recv_val  in  1  operands valid
- recv_rdy  out  1  block ready to accept operands
- ar, ac  in  n  real / imaginary part of dividend a
- br, bc  in  n  real / imaginary part of divisor b
- send_val  out  1  result valid
- send_rdy  in  1  consumer ready
- cr, cc  out  n  real / imaginary part of quotient c
- dbz  out  1  divide-by-zero flag, valid with send_val

## Operation
- Math: c = a·conj(b) / |b|².
  - num_r = ar·br + ac·bc
  - num_i = ac·br − ar·bc
  - den = br² + bc²
- Widths: products are full 2n-bit signed; num_r and num_i are 2n+1-bit signed; den is 2n+1-bit unsigned. No truncation before division.
- Quotient: q = (|num| << d) / den, integer division. The sign is applied afterwards, so rounding truncates toward zero.
  - Dividend is 2n+d bits; K = 2n+d quotient bits.
  - Real and imaginary divides run in parallel and share den.
- Saturation: if magnitude q > 2^(n−1)−1, clamp to 2^(n−1)−1, then negate if the sign is negative. Results range over ±(2^(n−1)−1); 0x80…0 is never produced.
- Divide by zero (den == 0): skip DIV, cr = cc = 0, dbz = 1. Otherwise dbz = 0.
- FSM states: IDLE, CALC, DIV, DONE.
  - IDLE: recv_rdy = 1. On recv_val & recv_rdy, latch ar, ac, br, bc and go to CALC.
  - CALC (1 cycle): register num_r, num_i, den and the two result signs. If den == 0, go to DONE; else clear the remainders and iteration counter, go to DIV.
  - DIV: one restoring-division step per cycle per component, MSB first. After K steps, apply saturation and sign, register cr/cc, go to DONE.
  - DONE: send_val = 1; cr, cc, dbz held stable. On send_val & send_rdy, go to IDLE.
- recv_rdy is high only in IDLE. Accept and send never overlap; there is no bypass path.
- Operand inputs are ignored outside the accepting cycle.

## Timing
- Reset (reset = 0 at a clock edge) takes effect from any state, including mid-DIV and DONE. After the edge:
  - state = IDLE, recv_rdy = 1
  - send_val = 0, cr = 0, cc = 0, dbz = 0
  - any in-flight result is discarded
- Latency is counted as edges after the accepting edge until send_val = 1:
  - normal: 1 (CALC) + K (DIV) + 1 = K+2 = 82 cycles at default n, d
  - divide by zero: 2 cycles
- Earliest next accept is one cycle after the send handshake, when recv_rdy returns to 1.
- Throughput at defaults: one result per 84 cycles when send_rdy is held high.
- Outputs are registered. No combinational path from recv_val/operands to send_val/cr/cc, or from send_rdy to recv_rdy.
- Backpressure: if send_rdy = 0, DONE holds indefinitely with cr/cc/dbz unchanged.
- send_rdy asserted before DONE has no effect.

## Test plan
All values below use n = 32, d = 16, Q16.16 hex.

- Identity: ar = 0x00010000, ac = 0, br = 0x00010000, bc = 0 -> cr = 0x00010000, cc = 0, dbz = 0; send_val rises exactly 82 cycles after the accept edge.
- General complex: a = 1+2j (0x00010000, 0x00020000), b = 3+4j (0x00030000, 0x00040000) -> cr = 0x000070A3, cc = 0x0000147A (0.44+0.08j, truncated).
- Negative and rounding: ar = 0xFFFF0000 (−1), ac = 0, br = 0x00030000, bc = 0 -> cr = 0xFFFFAAAB (−21845), cc = 0, confirming truncation toward zero.
- Divide by zero and saturation:
  - b = 0 -> dbz = 1, cr = cc = 0, send_val 2 cycles after accept.
  - ar = 0x7FFF0000, br = 0x00000001 -> cr = 0x7FFFFFFF.
  - ar = 0x80000000, br = 0x00000001 -> cr = 0x80000001.
  - cc = 0 and dbz = 0 in both saturation cases.
- Backpressure and reset:
  - Hold send_rdy = 0 for 20 cycles in DONE -> cr/cc stable, recv_rdy = 0 throughout; release -> send handshake, recv_rdy = 1 the next cycle.
  - Drive reset = 0 at DIV step 40 -> next cycle send_val = 0, recv_rdy = 1, cr = cc = 0; a fresh transaction then completes with correct values.
